// File: rtl/mult_pkg.sv
// Shared definitions for the sequential carry-save multiplier.
// The controller's state encoding and the default operand width live here.
package mult_pkg;

  localparam int MULT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/csa_fa.sv
// Single-bit full-adder cell.
// Used as the building block of the carry-save row.
module csa_fa (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ z;
  assign co = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/csa_row.sv
// One N-bit carry-save row: three operands in, bitwise sum and carry out.
// The carry is returned unshifted; the caller aligns it to the next weight.
module csa_row #(
  parameter int N = 16
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] z,
  output logic [N-1:0] sum,
  output logic [N-1:0] carry
);

  for (genvar i = 0; i < N; i++) begin : g_bit
    csa_fa u_fa (
      .x  (x[i]),
      .y  (y[i]),
      .z  (z[i]),
      .s  (sum[i]),
      .co (carry[i])
    );
  end

endmodule

// File: rtl/csa_mult_seq.sv
// Iterative unsigned WxW multiplier: one partial-product row folded into a
// registered sum/carry pair per cycle, then a single carry-propagate resolve.
module csa_mult_seq
  import mult_pkg::*;
#(
  parameter  int W  = MULT_W,
  localparam int CW = $clog2(W)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);

  localparam int N = 2 * W;

  state_t         state_q, state_d;
  logic [W-1:0]   a_r_q, a_r_d;
  logic [W-1:0]   b_r_q, b_r_d;
  logic [N-1:0]   s_q, s_d;
  logic [N-1:0]   c_q, c_d;
  logic [N-1:0]   prod_q, prod_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           out_valid_q, out_valid_d;
  logic           busy_q, busy_d;

  logic [N-1:0]   pp;
  logic [N-1:0]   row_sum;
  logic [N-1:0]   row_carry;
  logic           accept;

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign product   = prod_q;
  assign busy      = busy_q;

  // Every row is folded, even when the multiplier bit is zero, so latency is fixed.
  assign pp = b_r_q[cnt_q] ? ({{W{1'b0}}, a_r_q} << cnt_q) : '0;

  csa_row #(.N(N)) u_row (
    .x     (s_q),
    .y     (c_q),
    .z     (pp),
    .sum   (row_sum),
    .carry (row_carry)
  );

  always_comb begin
    state_d     = state_q;
    a_r_d       = a_r_q;
    b_r_d       = b_r_q;
    s_d         = s_q;
    c_d         = c_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          a_r_d   = a;
          b_r_d   = b;
          s_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        s_d   = row_sum;
        c_d   = row_carry << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        prod_d      = s_q + c_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          // A new operand pair may be taken on the same edge as the transfer.
          if (in_valid) begin
            a_r_d   = a;
            b_r_d   = b;
            s_d     = '0;
            c_d     = '0;
            cnt_d   = '0;
            state_d = ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == ACCUM) | (state_d == RESOLVE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_r_q       <= '0;
      b_r_q       <= '0;
      s_q         <= '0;
      c_q         <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_r_q       <= a_r_d;
      b_r_q       <= b_r_d;
      s_q         <= s_d;
      c_q         <= c_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule
